// File: rtl/muldiv_unit.sv
// muldiv_unit: RV64 M-extension execute unit (MUL / DIV / DIVU / REM / REMU,
// plus the *W word variants).
//
// A one-cycle multiply and a radix-2 restoring divider, both sequenced by a
// four-state FSM (IDLE, MUL, DIV, DONE).
//
// Ports
//   clk       in   1   clock; all state updates on the rising edge
//   reset     in   1   synchronous, active-high reset
//   valid_i   in   1   an M instruction occupies Execute this cycle
//   op_i      in   3   0=MUL 1=DIV 2=DIVU 3=REM 4=REMU (5-7 behave as MUL)
//   word_i    in   1   *W variant: 32-bit operands, result sign-extended
//   a_i, b_i  in  64   source operands, sampled on the accept cycle only
//   stall_i   in   1   DE register held by a data-memory stall
//   flush_i   in   1   abort the in-flight operation
//   doing_o   out  1   multicycle busy flag to the hazard unit
//   done_o    out  1   result_o is valid this cycle
//   result_o  out 64   final result
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  logic [2:0]  op_i,
    input  logic        word_i,
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        doing_o,
    output logic        done_o,
    output logic [63:0] result_o
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t state_q, state_d;

    logic [5:0]  cnt_q;
    logic        accept;

    // Operands and divider datapath (no reset needed: always loaded on accept)
    logic [63:0] a_q, b_q;
    logic [63:0] div_mag_q;   // divisor magnitude
    logic [63:0] dq_q;        // dividend bits shifting out, quotient bits in
    logic [63:0] rem_q;       // partial remainder
    logic        word_q, is_rem_q, neg_q_q, neg_r_q;

    function automatic logic signed [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] apply_sign(input logic [63:0] v, input logic neg);
        return neg ? (64'd0 - v) : v;
    endfunction

    // Accept-cycle decode
    logic        op_div, op_signed, op_rem;
    logic [63:0] a_ext, b_ext, a_mag, b_mag;
    logic        div_zero, div_ovf, special;
    logic [63:0] special_res;

    always_comb begin
        op_div    = (op_i >= 3'd1) && (op_i <= 3'd4);
        op_signed = (op_i == 3'd1) || (op_i == 3'd3);
        op_rem    = (op_i == 3'd3) || (op_i == 3'd4);

        // Word operands are extended according to signedness so that the
        // 64-bit magnitude logic handles both widths.
        if (word_i) begin
            a_ext = op_signed ? sext32(a_i[31:0]) : {32'd0, a_i[31:0]};
            b_ext = op_signed ? sext32(b_i[31:0]) : {32'd0, b_i[31:0]};
        end else begin
            a_ext = a_i;
            b_ext = b_i;
        end
        a_mag = apply_sign(a_ext, op_signed & a_ext[63]);
        b_mag = apply_sign(b_ext, op_signed & b_ext[63]);

        div_zero = word_i ? (b_i[31:0] == 32'd0) : (b_i == 64'd0);
        div_ovf  = op_signed &&
                   (word_i ? ((a_i[31:0] == 32'h8000_0000) && (b_i[31:0] == 32'hFFFF_FFFF))
                           : ((a_i == 64'h8000_0000_0000_0000) && (b_i == 64'hFFFF_FFFF_FFFF_FFFF)));
        special  = op_div && (div_zero || div_ovf);

        // Dividend as seen by the result: word variants sign-extend from bit 31
        if (div_zero)
            special_res = op_rem ? (word_i ? sext32(a_i[31:0]) : a_i) : 64'hFFFF_FFFF_FFFF_FFFF;
        else
            special_res = op_rem ? 64'd0 : (word_i ? sext32(a_i[31:0]) : a_i);
    end

    // One restoring-division step per DIV cycle
    logic [64:0] shifted, diff;
    logic        qbit;
    logic [63:0] rem_nx, dq_nx, q_mag, q_fin, r_fin, div_sel, div_res;

    always_comb begin
        shifted = {rem_q, dq_q[63]};
        diff    = shifted - {1'b0, div_mag_q};
        qbit    = ~diff[64];
        rem_nx  = qbit ? diff[63:0] : shifted[63:0];
        dq_nx   = {dq_q[62:0], qbit};
        q_mag   = word_q ? {32'd0, dq_nx[31:0]} : dq_nx;
        q_fin   = apply_sign(q_mag, neg_q_q);
        r_fin   = apply_sign(rem_nx, neg_r_q);
        div_sel = is_rem_q ? r_fin : q_fin;
        div_res = word_q ? sext32(div_sel[31:0]) : div_sel;
    end

    logic [63:0] prod, mul_res;

    always_comb begin
        prod    = a_q * b_q;
        mul_res = word_q ? sext32(prod[31:0]) : prod;
    end

    // Next state and busy flag
    always_comb begin
        state_d = state_q;
        doing_o = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                doing_o = valid_i;
                if (valid_i && !flush_i) begin
                    accept = 1'b1;
                    if (special)     state_d = S_DONE;
                    else if (op_div) state_d = S_DIV;
                    else             state_d = S_MUL;
                end
            end
            S_MUL: begin
                doing_o = 1'b1;
                state_d = S_DONE;
            end
            S_DIV: begin
                doing_o = 1'b1;
                if (cnt_q == 6'd0) state_d = S_DONE;
            end
            S_DONE: begin
                if (!stall_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d = S_IDLE;
            doing_o = 1'b0;
            accept  = 1'b0;
        end
        if (reset) begin
            state_d = S_IDLE;
            doing_o = 1'b0;
            accept  = 1'b0;
        end
    end

    assign done_o = (state_q == S_DONE);

    // Control state, iteration counter and the result register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            result_o <= 64'd0;
        end else begin
            state_q <= state_d;
            if (accept)
                cnt_q <= word_i ? 6'd31 : 6'd63;
            else if (state_q == S_DIV && cnt_q != 6'd0)
                cnt_q <= cnt_q - 6'd1;
            if (state_d == S_DONE && state_q != S_DONE) begin
                unique case (state_q)
                    S_IDLE:  result_o <= special_res;
                    S_MUL:   result_o <= mul_res;
                    default: result_o <= div_res;
                endcase
            end
        end
    end

    // Operand latch and divider iteration
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q       <= a_i;
            b_q       <= b_i;
            word_q    <= word_i;
            is_rem_q  <= op_rem;
            neg_q_q   <= op_signed & (a_ext[63] ^ b_ext[63]);
            neg_r_q   <= op_signed & a_ext[63];
            div_mag_q <= b_mag;
            rem_q     <= 64'd0;
            // Word dividends start at the top so the MSB-first shift sees them first
            dq_q      <= word_i ? {a_mag[31:0], 32'd0} : a_mag;
        end else if (state_q == S_DIV) begin
            rem_q <= rem_nx;
            dq_q  <= dq_nx;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit. Cycle 0 is the cycle valid_i is
// presented; inputs change 1ns after a rising edge, outputs are sampled on
// the falling edge.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, valid, word, stall, flush;
    logic [2:0]  op;
    logic [63:0] a, b;
    logic        doing, done;
    logic [63:0] result;

    int tests = 0;
    int fails = 0;

    muldiv_unit dut (
        .clk      (clk),
        .reset    (reset),
        .valid_i  (valid),
        .op_i     (op),
        .word_i   (word),
        .a_i      (a),
        .b_i      (b),
        .stall_i  (stall),
        .flush_i  (flush),
        .doing_o  (doing),
        .done_o   (done),
        .result_o (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation with valid held until done; checks latency,
    // busy flag on every cycle, and the final result.
    task automatic run_op(input string tag, input logic [2:0] o, input logic w,
                          input logic [63:0] x, input logic [63:0] y,
                          input int exp_lat, input logic [63:0] exp_res);
        int lat;
        lat   = -1;
        valid = 1'b1;
        op    = o;
        word  = w;
        a     = x;
        b     = y;
        @(negedge clk);
        check({tag, " doing c0"}, doing, 1);
        check({tag, " done c0"}, done, 0);
        for (int c = 1; c <= 100 && lat < 0; c++) begin
            @(negedge clk);
            if (done) lat = c;
            else check($sformatf("%s doing c%0d", tag, c), doing, 1);
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, result, exp_res);
        check({tag, " doing in done"}, doing, 0);
        step();
        valid = 1'b0;
    endtask

    initial begin
        int seen;
        reset = 1'b1; valid = 1'b0; word = 1'b0; stall = 1'b0; flush = 1'b0;
        op = 3'd0; a = 64'd0; b = 64'd0;
        step();
        step();
        valid = 1'b1;
        @(negedge clk);
        check("reset doing", doing, 0);
        check("reset done", done, 0);
        check("reset result", result, 0);
        step();
        reset = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        check("idle done", done, 0);
        check("idle doing", doing, 0);
        step();

        // Basic function, consecutive calls also exercise back-to-back accept
        run_op("MUL 7*-3", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 2, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("DIV -20/6", 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 65, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("REM -20%6", 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 65, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("DIVUW", 3'd2, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 33, 64'h0000_0000_7FFF_FFFF);
        run_op("DIV by 0", 3'd1, 1'b0, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("REM by 0", 3'd3, 1'b0, 64'd5, 64'd0, 1, 64'd5);
        run_op("DIV ovf", 3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1,
               64'h8000_0000_0000_0000);
        run_op("REM ovf", 3'd3, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd0);
        run_op("MULW", 3'd0, 1'b1, 64'hABCD_0000_7FFF_FFFF, 64'd2, 2, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("MUL reserved op", 3'd7, 1'b0, 64'd3, 64'd4, 2, 64'd12);
        run_op("REMU 100%7", 3'd4, 1'b0, 64'd100, 64'd7, 65, 64'd2);
        run_op("DIVU max/1", 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("DIVW -7/2", 3'd1, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("REMW -7%2", 3'd3, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("DIVW ovf", 3'd1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1,
               64'hFFFF_FFFF_8000_0000);
        run_op("REMUW by 0", 3'd4, 1'b1, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000, 1,
               64'hFFFF_FFFF_8000_0001);

        // Flush in IDLE with valid: no accept
        valid = 1'b1; op = 3'd0; word = 1'b0; a = 64'd9; b = 64'd9; flush = 1'b1;
        @(negedge clk);
        check("flush idle doing", doing, 0);
        step();
        valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush idle no accept doing", doing, 0);
        step();
        @(negedge clk);
        check("flush idle no done", done, 0);
        step();

        // Stall in DONE for three cycles, valid held throughout
        valid = 1'b1; op = 3'd0; word = 1'b0; a = 64'd3; b = 64'd5; stall = 1'b1;
        step();
        step();
        @(negedge clk);
        check("stall c2 done", done, 1);
        check("stall c2 result", result, 64'd15);
        for (int c = 3; c <= 4; c++) begin
            step();
            @(negedge clk);
            check($sformatf("stall c%0d done", c), done, 1);
            check($sformatf("stall c%0d result", c), result, 64'd15);
            check($sformatf("stall c%0d doing", c), doing, 0);
        end
        step();
        stall = 1'b0; valid = 1'b0;
        @(negedge clk);
        check("stall release done", done, 1);
        step();
        @(negedge clk);
        check("after stall idle done", done, 0);
        check("after stall idle doing", doing, 0);
        step();
        run_op("MUL after stall", 3'd0, 1'b0, 64'd2, 64'd2, 2, 64'd4);

        // Flush mid-divide at cycle 10
        valid = 1'b1; op = 3'd1; word = 1'b0; a = 64'd100; b = 64'd7;
        @(negedge clk);
        seen = 0;
        for (int c = 1; c <= 9; c++) begin
            step();
            @(negedge clk);
            if (done) seen++;
        end
        step();
        flush = 1'b1;
        @(negedge clk);
        check("flush c10 doing", doing, 0);
        check("flush c10 done", done, 0);
        step();
        flush = 1'b0; valid = 1'b0;
        @(negedge clk);
        check("flush c11 doing", doing, 0);
        for (int c = 11; c <= 90; c++) begin
            if (done) seen++;
            step();
            @(negedge clk);
        end
        check("flush done never", 64'(seen), 0);
        step();

        // Reset mid-divide at cycle 10
        valid = 1'b1; op = 3'd1; word = 1'b0; a = 64'd100; b = 64'd7;
        for (int c = 1; c <= 10; c++) step();
        reset = 1'b1;
        @(negedge clk);
        check("reset c10 doing", doing, 0);
        step();
        reset = 1'b0; valid = 1'b0;
        @(negedge clk);
        check("reset c11 doing", doing, 0);
        check("reset c11 done", done, 0);
        check("reset c11 result", result, 0);
        step();
        run_op("DIV after reset", 3'd1, 1'b0, 64'd100, 64'd7, 65, 64'd14);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: valid_i  input  1  an M-extension instruction occupies Execute this cycle.
REQ-004 SHALL have port: op_i  input  3  0=MUL, 1=DIV, 2=DIVU, 3=REM, 4=REMU; 5-7 reserved, treated as MUL.
REQ-005 SHALL have port: word_i  input  1  *W variant: use low 32 bits; sign-extend the 32-bit result to 64.
REQ-006 SHALL have port: a_i, b_i  input  64 each  source operands; sampled only on the accept cycle.
REQ-007 SHALL have port: stall_i  input  1  the DE register is held by a data-memory stall (~d_data_ok).
REQ-008 SHALL have port: flush_i  input  1  abort the in-flight operation.
REQ-009 SHALL have port: doing_o  output  1  multicycle_doing to the hazard unit; holds PC/FD/DE and bubbles EM.
REQ-010 SHALL have port: done_o  output  1  result_o valid this cycle.
REQ-011 SHALL have port: result_o  output  64  final result.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-013 IDLE with valid_i=1 and flush_i=0 SHALL accept: latch op, word, a, b.
- Go to DONE if division by zero or signed overflow.
- Else go to MUL for op MUL, or DIV for the divide ops.
REQ-014 doing_o SHALL equal valid_i in IDLE (combinational), 1 in MUL and DIV, and 0 in DONE.
REQ-015 doing_o SHALL be 0 whenever flush_i=1 or reset=1.
REQ-016 MUL SHALL last exactly 1 cycle and compute the low 64 bits of the product (low 32 sign-extended if word), then go to DONE.
- Result: valid_i at cycle 0 -> done_o at cycle 2.
REQ-017 DIV SHALL be a radix-2 restoring divider on operand magnitudes, one quotient bit per cycle.
- Iterations: 64, or 32 if word.
- Signs applied on exit: quotient negative iff signs differ; remainder takes the dividend's sign.
- Result: done_o at cycle 65, or cycle 33 if word.
REQ-018 Divide by zero SHALL give quotient = all ones and remainder = dividend, with done_o at cycle 1.
REQ-019 Signed overflow SHALL give quotient = dividend and remainder = 0, with done_o at cycle 1.
- 64-bit case: dividend = 0x8000_0000_0000_0000, divisor = -1.
- Word case: dividend = 0x8000_0000, divisor = -1.
REQ-020 Word results, including the REQ-018/019 cases, SHALL be sign-extended from bit 31.
REQ-021 In DONE, done_o SHALL be 1 and result_o SHALL hold the result.
- stall_i=1: remain in DONE.
- stall_i=0: go to IDLE next cycle.
- valid_i is ignored in DONE, so the retiring instruction never restarts.
REQ-022 A back-to-back M instruction SHALL be accepted in the IDLE cycle after DONE.
REQ-023 flush_i=1 in any state SHALL force IDLE next cycle with done_o=0; no accept occurs in that cycle.
REQ-024 done_o SHALL be 0 in IDLE, MUL and DIV.
REQ-025 result_o SHALL change only when entering DONE.

Reset
REQ-026 reset=1 SHALL force the following on the next edge, regardless of state (including mid-divide):
- state = IDLE, done_o = 0, result_o = 0, iteration counter = 0.
- doing_o = 0 from that edge on.
REQ-027 reset SHALL take priority over flush_i and valid_i.

Verification
REQ-028 MUL: a=7, b=-3, op=0, word=0, valid held -> doing_o=1 in cycles 0-1; cycle 2: done_o=1, result=0xFFFF_FFFF_FFFF_FFEB, doing_o=0.
REQ-029 DIV/REM 64-bit: a=-20, b=6, op=1 -> done_o at cycle 65, result=-3 (0xFFFF_FFFF_FFFF_FFFD); same operands with op=3 -> result=-2.
REQ-030 DIVUW: a=0xFFFF_FFFF, b=2, op=2, word=1 -> done_o at cycle 33, result=0x0000_0000_7FFF_FFFF.
REQ-031 Special cases, each with done_o at cycle 1:
- DIV with b=0, a=5 -> result=0xFFFF_FFFF_FFFF_FFFF.
- REM with b=0, a=5 -> result=5.
- DIV with a=0x8000_0000_0000_0000, b=-1 -> result=a.
REQ-032 Stall in DONE: hold stall_i=1 for 3 cycles -> done_o and result stay stable, no restart; release -> IDLE, then the next valid_i is accepted.
REQ-033 Abort mid-divide:
- flush_i=1 at cycle 10 -> IDLE at cycle 11, done_o never asserted, doing_o=0 in cycle 10.
- Repeat with reset=1 at cycle 10 -> all outputs 0 at cycle 11.
